// File: rtl/sys_dpram_mm.sv
// Dual-port Avalon-MM RAM with an optional post-reset clear sweep, byte enables,
// same-address write arbitration (s1 wins) and a 1- or 2-cycle registered read path.
module sys_dpram_mm #(
  parameter int unsigned       DATA_W        = 32,
  parameter int unsigned       ADDR_W        = 15,
  parameter int unsigned       READ_LATENCY  = 1,
  parameter bit                INIT_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE   = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W-1:0]   s2_writedata,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest,
  output logic                init_done
);

  localparam int unsigned BeW   = DATA_W / 8;
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic                   clr_we;
  logic [DATA_W-1:0]      mem [Depth];

  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0][BeW-1:0]    be;
  logic [1:0]             req_rd, req_wr, wait_req, rd_acc, wr_acc;
  logic                   collide;

  logic [1:0]             vld1_q, vld1_d, vld2_q, vld2_d, vld_out;
  logic [1:0][DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, rd_out;

  assign addr  = {s2_address, s1_address};
  assign wdata = {s2_writedata, s1_writedata};
  assign be    = {s2_byteenable, s1_byteenable};

  // A simultaneous read+write on one port is treated as a write only.
  assign req_wr  = {s2_chipselect & s2_write, s1_chipselect & s1_write};
  assign req_rd  = {s2_chipselect & s2_read & ~s2_write, s1_chipselect & s1_read & ~s1_write};
  assign collide = (&req_wr) & (addr[0] == addr[1]);

  always_comb begin
    wait_req = 2'b11;
    if (reset_n && clken && (state_q == StReady)) begin
      wait_req = {collide, 1'b0};
    end
  end

  assign rd_acc = req_rd & ~wait_req;
  assign wr_acc = req_wr & ~wait_req;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    if (clken && (state_q == StClear)) begin
      clr_we    = 1'b1;
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (&clr_cnt_q) begin
        state_d = StReady;
      end
    end
  end

  // Read data is sampled from the array before this edge's writes land (old-data semantics).
  always_comb begin
    vld1_d = vld1_q;
    vld2_d = vld2_q;
    rd1_d  = rd1_q;
    rd2_d  = rd2_q;
    if (clken) begin
      vld1_d = rd_acc;
      vld2_d = vld1_q;
      for (int p = 0; p < 2; p++) begin
        if (rd_acc[p]) begin
          rd1_d[p] = mem[addr[p]];
        end
        if (vld1_q[p]) begin
          rd2_d[p] = rd1_q[p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= INIT_ON_RESET ? StClear : StReady;
      clr_cnt_q <= '0;
      vld1_q    <= '0;
      vld2_q    <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      vld1_q    <= vld1_d;
      vld2_q    <= vld2_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
    end
  end

  // Storage is deliberately not reset; the clear sweep and user writes never overlap.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= CLEAR_VALUE;
    end
    for (int p = 0; p < 2; p++) begin
      if (wr_acc[p]) begin
        for (int b = 0; b < BeW; b++) begin
          if (be[p][b]) begin
            mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
          end
        end
      end
    end
  end

  assign rd_out  = (READ_LATENCY == 2) ? rd2_q : rd1_q;
  assign vld_out = (READ_LATENCY == 2) ? vld2_q : vld1_q;

  assign s1_readdata      = rd_out[0];
  assign s2_readdata      = rd_out[1];
  assign s1_readdatavalid = vld_out[0] & clken;
  assign s2_readdatavalid = vld_out[1] & clken;
  assign s1_waitrequest   = wait_req[0];
  assign s2_waitrequest   = wait_req[1];
  assign init_done        = reset_n & (state_q == StReady);

endmodule

// File: doc/sys_dpram_mm.md
SYS_DPRAM_MM -- requirements
Module: sys_dpram_mm

Interface
REQ-001 Parameter DATA_W, default 32: data width in bits; legal values are multiples of 8, from 8 to 128.
REQ-002 Parameter ADDR_W, default 15: word address width; depth is 2^ADDR_W words.
REQ-003 Parameter READ_LATENCY, default 1: cycles from accepted read to readdatavalid; legal values are 1 and 2.
REQ-004 Parameter INIT_ON_RESET, default 1: 1 = hardware clear sweep after reset; 0 = no sweep, READY immediately.
REQ-005 Parameter CLEAR_VALUE, default 0: DATA_W-bit word written by the clear sweep.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  single clock; all logic rising-edge.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 clken  in  1  global clock enable; 0 freezes all state.
REQ-010 sN_address  in  ADDR_W  word address, N = 1, 2.
REQ-011 sN_chipselect, sN_read, sN_write  in  1 each  Avalon-MM slave controls.
REQ-012 sN_writedata  in  DATA_W  write data.
REQ-013 sN_byteenable  in  DATA_W/8  per-byte write enable.
REQ-014 sN_readdata  out  DATA_W  read data, registered.
REQ-015 sN_readdatavalid  out  1  one-cycle pulse per accepted read.
REQ-016 sN_waitrequest  out  1  request not accepted this cycle.
REQ-017 init_done  out  1  high in READY state.

Function
REQ-018 Request on port N = sN_chipselect & (sN_read | sN_write); the request is accepted when sN_waitrequest=0 and clken=1.
REQ-019 sN_read and sN_write both high with chipselect: write takes effect, read is ignored, no readdatavalid.
REQ-020 FSM states: CLEAR, READY.
REQ-021 Reset-exit state is CLEAR if INIT_ON_RESET=1, else READY.
REQ-022 CLEAR: a counter starting at 0 writes CLEAR_VALUE (all bytes) at one address per enabled cycle; after writing address 2^ADDR_W-1, go to READY on the next edge; the counter wraps to 0.
REQ-023 In CLEAR, both waitrequests are 1 and no user request is accepted.
REQ-024 In READY, sN_waitrequest is combinational and is 1 only under REQ-027 or clken=0.
REQ-025 Writes update only the bytes with byteenable=1; the update is visible to reads accepted on the following cycle.
REQ-026 Read latency is exactly READ_LATENCY cycles: data is captured at acceptance; at READ_LATENCY=2 an extra output register is added. Back-to-back reads are accepted every cycle with throughput of 1 per port.
REQ-027 Same-address write collision, both ports writing the same address in the same cycle: s1 is accepted; s2_waitrequest=1 that cycle; s2 is accepted on the next cycle if still asserted.
REQ-028 Read/write on the same address in the same cycle, same or opposite port: the read returns the pre-write (old) data.
REQ-029 Different-address simultaneous accesses on both ports proceed with no stall.
REQ-030 clken=0: FSM, clear counter, memory, and read pipeline hold; readdatavalid is forced 0; waitrequests are 1; pending read data re-emerges once clken returns to 1.
REQ-031 readdata holds its last value when readdatavalid=0.

Reset
REQ-032 Asserting reset_n=0 asynchronously clears: clear counter = 0, all readdatavalid = 0, all readdata = 0, the read pipeline, and init_done = 0; waitrequests = 1.
REQ-033 Reset during CLEAR restarts the sweep at address 0; reset during READY discards in-flight reads, so no readdatavalid is issued for them.
REQ-034 Memory contents are not reset by reset_n; with INIT_ON_RESET=0, contents are undefined until written.
REQ-035 Reset deassertion is treated synchronously; the first CLEAR write occurs on the first enabled edge after release.

Verification
REQ-036 ADDR_W=4, INIT_ON_RESET=1, CLEAR_VALUE=0xA5A5A5A5, release reset -> init_done rises exactly 16 enabled cycles later; a read of each address returns 0xA5A5A5A5; waitrequests are 1 throughout CLEAR.
REQ-037 s1 writes 0x11223344 to address 3 with byteenable=4'b0101, then s2 reads address 3 -> readdata = 0xA522A544 after READ_LATENCY cycles, with one readdatavalid pulse (run at both latencies).
REQ-038 Both ports write address 7 in the same cycle (s1=0x1, s2=0x2) -> s2_waitrequest=1 for one cycle; final content 0x2; a read issued in the collision cycle returns the prior value.
REQ-039 s1 streams reads of addresses 0..15 back-to-back while s2 writes 15..0 -> no waitrequests; 16 consecutive readdatavalid pulses; each read data word equals the memory value prior to the same-cycle write.
REQ-040 Drop clken for 3 cycles while a READ_LATENCY=2 read is in flight -> no readdatavalid during the hold; the valid pulse appears 2 enabled cycles after acceptance.
REQ-041 Assert reset_n at clear count 9 -> sweep restarts at 0; init_done rises 16 enabled cycles after release; any pending readdatavalid is suppressed.
